bcd_display_scanner: RTL and testbench

- Downstream consumer of the timer tracker's 16-bit packed-BCD time word (MM:SS).
- Time-multiplexes the four BCD digits onto a common-anode 4-digit seven-segment display.
- Drives the colon decimal point and blinks the digit under edit in adjust mode.
- Latches the time word once per scan frame so a digit never tears mid-frame.

---
 rtl/bcd_display_scanner_pkg.sv | 26 ++
 rtl/bcd_to_seg.sv | 32 +++
 rtl/bcd_display_scanner.sv | 92 +++++++++
 tb/tb_bcd_display_scanner.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_display_scanner_pkg.sv
// Shared constants and types for the BCD display scanner: active-low segment
// patterns {g,f,e,d,c,b,a}, mode encodings and the digit-index type.
package bcd_display_scanner_pkg;

  typedef logic [1:0] digit_idx_t;

  typedef enum logic [1:0] {
    MODE_RUN    = 2'd0,
    MODE_ADJUST = 2'd1,
    MODE_PAUSE  = 2'd2
  } mode_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational nibble to active-low seven-segment pattern; non-BCD nibbles
// show a dash, and the blank override turns every segment off.
module bcd_to_seg
  import bcd_display_scanner_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (nibble)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Scans a packed-BCD MM:SS word onto a 4-digit common-anode display, with a
// colon on digit 2, blink of the edited digit and a per-frame time latch.
module bcd_display_scanner
  import bcd_display_scanner_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] time_bcd,
  input  logic [1:0]  mode,
  input  logic [1:0]  sel_digit,
  input  logic        blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);

  logic [RW-1:0] refresh_cnt;
  logic [BW-1:0] blink_cnt;
  digit_idx_t    idx;
  logic          phase;
  logic [15:0]   shadow;
  logic          refresh_wrap;
  logic          blink_wrap;

  assign refresh_wrap = (refresh_cnt == RW'(REFRESH_DIV - 1));
  assign blink_wrap   = (blink_cnt == BW'(BLINK_DIV - 1));

  // The shadow word only changes as the scan leaves digit 3, so a frame never tears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh_cnt <= '0;
      idx         <= '0;
      shadow      <= 16'h0000;
    end else if (refresh_wrap) begin
      refresh_cnt <= '0;
      idx         <= idx + 2'd1;
      if (idx == 2'd3) shadow <= time_bcd;
    end else begin
      refresh_cnt <= refresh_cnt + RW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (blink_wrap) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  logic [3:0] nibble;
  logic       digit_blank;
  logic [6:0] seg_nxt;
  logic [3:0] an_nxt;
  logic       dp_nxt;

  assign nibble      = shadow[{idx, 2'b00} +: 4];
  assign digit_blank = blank | ((mode == MODE_ADJUST) && (idx == sel_digit) && !phase);

  bcd_to_seg u_bcd_to_seg (
    .nibble (nibble),
    .blank  (digit_blank),
    .seg    (seg_nxt)
  );

  assign an_nxt = digit_blank ? 4'b1111 : ~(4'b0001 << idx);
  // Colon lives on digit 2; while paused it flashes with the blink phase.
  assign dp_nxt = !((idx == 2'd2) && !digit_blank && ((mode != MODE_PAUSE) || phase));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner: every cycle the expected {an,seg,dp}
// from an independent arithmetic model is queued and compared after the edge.
module tb_bcd_display_scanner;

  localparam int RD = 4;
  localparam int BD = 16;
  localparam int FR = 4 * RD;
  localparam logic [11:0] RST_OUT = 12'hFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] time_bcd = 16'h0000;
  logic [1:0]  mode = 2'd0;
  logic [1:0]  sel_digit = 2'd0;
  logic        blank = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  bcd_display_scanner #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
    .clk       (clk),
    .rst       (rst),
    .time_bcd  (time_bcd),
    .mode      (mode),
    .sel_digit (sel_digit),
    .blank     (blank),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          kcnt = 0;
  logic [15:0] m_shadow = 16'h0000;
  logic [11:0] exp_q[$];

  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Expected outputs produced by the edge that follows model state kcnt.
  function automatic logic [11:0] model_out();
    int         di;
    bit         ph;
    bit         bl;
    logic [3:0] a;
    logic [3:0] nib;
    logic       d;
    di = (kcnt / RD) % 4;
    ph = ((kcnt / BD) % 2) == 0;
    bl = blank || (mode == 2'd1 && int'(sel_digit) == di && !ph);
    if (bl) return RST_OUT;
    a   = 4'b1111;
    a[di] = 1'b0;
    nib = m_shadow[di*4 +: 4];
    d   = !(di == 2 && (mode != 2'd2 || ph));
    return {a, dec(nib), d};
  endfunction

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed {an,seg,dp}=%b_%b_%b expected=%b_%b_%b",
             tag, obs[11:8], obs[7:1], obs[0], expv[11:8], expv[7:1], expv[0]);
    end
  endtask

  task automatic step(input int n, input string tag);
    repeat (n) begin
      @(posedge clk);
      if (!rst) begin
        exp_q.push_back(RST_OUT);
      end else begin
        exp_q.push_back(model_out());
        kcnt++;
        if (kcnt % FR == 0) m_shadow = time_bcd;
      end
      #1;
      check(tag, {an, seg, dp}, exp_q.pop_front());
    end
  endtask

  // Advance until the observed output is digit 0 of a fresh frame.
  task automatic sync_frame(input string tag);
    do step(1, tag); while ((kcnt - 1) % FR != 0);
  endtask

  task automatic assert_reset();
    rst = 1'b0;
    kcnt = 0;
    m_shadow = 16'h0000;
    #1;
    check("async_reset", {an, seg, dp}, RST_OUT);
  endtask

  initial begin
    time_bcd = 16'h0500;
    step(3, "in_reset");
    rst = 1'b1;
    sync_frame("frame0");
    sync_frame("frame0");
    check("f1_d0", {an, seg, dp}, {4'b1110, 7'b1000000, 1'b1});
    step(4, "scan");
    check("f1_d1", {an, seg, dp}, {4'b1101, 7'b1000000, 1'b1});
    step(2, "scan");
    time_bcd = 16'h0501;
    step(2, "scan");
    check("f1_d2_nochg", {an, seg, dp}, {4'b1011, 7'b0010010, 1'b0});
    step(4, "scan");
    check("f1_d3_nochg", {an, seg, dp}, {4'b0111, 7'b1000000, 1'b1});
    sync_frame("scan");
    check("f2_d0_new", {an, seg, dp}, {4'b1110, 7'b1111001, 1'b1});

    time_bcd = 16'h0A59;
    sync_frame("scan");
    check("dash_d0", {an, seg, dp}, {4'b1110, 7'b0010000, 1'b1});
    step(4, "scan");
    check("dash_d1", {an, seg, dp}, {4'b1101, 7'b0010010, 1'b1});
    step(4, "scan");
    check("dash_d2", {an, seg, dp}, {4'b1011, 7'b0111111, 1'b0});

    time_bcd  = 16'h0500;
    mode      = 2'd1;
    sel_digit = 2'd2;
    sync_frame("adjust");
    for (int f = 0; f < 4; f++) begin
      step(8, "adjust");
      check("adjust_d2", {an, seg, dp},
            (f % 2 == 0) ? {4'b1011, 7'b0010010, 1'b0} : RST_OUT);
      step(8, "adjust");
    end

    mode = 2'd2;
    for (int f = 0; f < 2; f++) begin
      step(8, "pause");
      check("pause_d2", {an, seg, dp}, {4'b1011, 7'b0010010, (f % 2 == 0) ? 1'b0 : 1'b1});
      step(8, "pause");
    end

    mode = 2'd3;
    step(16, "mode3");
    blank = 1'b1;
    mode  = 2'd1;
    for (int i = 0; i < 20; i++) begin
      step(1, "blank");
      check("blank_const", {an, seg, dp}, RST_OUT);
    end

    blank = 1'b0;
    mode  = 2'd0;
    step(6, "pre_reset");
    assert_reset();
    step(3, "in_reset");
    rst = 1'b1;
    step(5, "after_reset");
    blank = 1'b1;
    step(3, "blank");
    assert_reset();
    step(3, "in_reset_blank");
    rst   = 1'b1;
    blank = 1'b0;
    sync_frame("restart");
    sync_frame("restart");
    check("restart_d0", {an, seg, dp}, {4'b1110, 7'b1000000, 1'b1});
    step(32, "tail");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
